// File: rtl/udc_pkg.sv
// Shared encodings and the next-count/boundary function for updown_counter_mod.
package udc_pkg;

    localparam logic UDC_UP   = 1'b1;
    localparam logic UDC_DOWN = 1'b0;
    localparam logic UDC_WRAP = 1'b0;
    localparam logic UDC_SAT  = 1'b1;

    typedef struct packed {
        logic [31:0] count;
        logic        ovf_evt;
        logic        unf_evt;
    } udc_step_t;

    // Operands are zero-extended to 32 bits; sums are kept in 33 bits so
    // count+step never aliases back into range.
    function automatic udc_step_t udc_next(
        input logic [31:0] cnt,
        input logic [31:0] max_val,
        input logic [31:0] step,
        input logic        up,
        input logic        sat
    );
        udc_step_t   r;
        logic [32:0] sum;
        r   = '0;
        sum = '0;
        if (up == UDC_UP) begin
            sum = {1'b0, cnt} + {1'b0, step};
            if (sum <= {1'b0, max_val}) begin
                r.count = sum[31:0];
            end else begin
                r.ovf_evt = 1'b1;
                sum       = sum - {1'b0, max_val} - 33'd1;
                r.count   = (sat == UDC_SAT) ? max_val : sum[31:0];
            end
        end else begin
            if (cnt >= step) begin
                r.count = cnt - step;
            end else begin
                r.unf_evt = 1'b1;
                sum       = {1'b0, cnt} + {1'b0, max_val} + 33'd1 - {1'b0, step};
                r.count   = (sat == UDC_SAT) ? 32'd0 : sum[31:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/udc_if.sv
// Control/status bundle of updown_counter_mod; master drives controls, slave is the counter.
interface udc_if #(
    parameter int WIDTH = 8
) ();

    logic             en;
    logic             load;
    logic [WIDTH-1:0] d_in;
    logic             up;
    logic             sat;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             unf;
    logic             at_max;
    logic             at_min;

    modport master (
        output en, load, d_in, up, sat, clr_flags,
        input  count, tc, ovf, unf, at_max, at_min
    );

    modport slave (
        input  en, load, d_in, up, sat, clr_flags,
        output count, tc, ovf, unf, at_max, at_min
    );

endinterface

// File: rtl/udc_prescaler.sv
// Enable divider: tick is high in the en cycle that ends each PRESCALE-long phase.
module udc_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PH_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PRESCALE - 1);

    logic [PH_W-1:0] phase;

    assign tick = en && (phase == PH_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Loadable up/down counter with programmable modulus/step, wrap or saturate, tc pulse and sticky flags.
// Define UDC_PRESCALER_EN to divide the count enable by PRESCALE.
module updown_counter_mod
    import udc_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int unsigned STEP     = 1,
    parameter int          PRESCALE = 4
) (
    input logic   clk,
    input logic   rst,
    udc_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    if (WIDTH < 2 || WIDTH > 31) begin : g_chk_width
        $error("updown_counter_mod: WIDTH must be in 2..31");
    end
    if (longint'(MAX_VAL) > ((64'sd1 <<< WIDTH) - 64'sd1)) begin : g_chk_max
        $error("updown_counter_mod: MAX_VAL does not fit in WIDTH bits");
    end
    if (STEP < 1 || STEP > MAX_VAL) begin : g_chk_step
        $error("updown_counter_mod: STEP must be in 1..MAX_VAL");
    end
    if (PRESCALE < 2) begin : g_chk_pre
        $error("updown_counter_mod: PRESCALE must be at least 2");
    end
    if ($bits(bus.count) != WIDTH) begin : g_chk_bus
        $error("updown_counter_mod: interface WIDTH differs from counter WIDTH");
    end

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;
    logic             unf_q;
    logic             step;
    logic [WIDTH-1:0] load_val;
    udc_step_t        nxt;
    logic             unused_hi;

`ifdef UDC_PRESCALER_EN
    logic tick;

    udc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load),
        .en   (bus.en),
        .tick (tick)
    );

    assign step = bus.en && tick;
`else
    assign step = bus.en;
`endif

    assign load_val = (32'(bus.d_in) > MAX_VAL) ? MAX_W : bus.d_in;

    always_comb begin
        nxt = udc_next(32'(count_q), 32'(MAX_VAL), 32'(STEP), bus.up, bus.sat);
    end

    // The result never exceeds MAX_VAL, so the upper bits are always zero.
    assign unused_hi = |nxt.count[31:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tc_q  <= 1'b0;
            ovf_q <= ovf_q && !bus.clr_flags;
            unf_q <= unf_q && !bus.clr_flags;
            if (bus.load) begin
                count_q <= load_val;
            end else if (step) begin
                count_q <= nxt.count[WIDTH-1:0];
                tc_q    <= nxt.ovf_evt || nxt.unf_evt;
                if (nxt.ovf_evt) ovf_q <= 1'b1;
                if (nxt.unf_evt) unf_q <= 1'b1;
            end
        end
    end

    assign bus.count  = count_q;
    assign bus.tc     = tc_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
    assign bus.at_max = (count_q == MAX_W);
    assign bus.at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed checks of updown_counter_mod: WIDTH=4, MAX_VAL=9 with STEP=1 and STEP=3.
module tb_updown_counter_mod;
    import udc_pkg::*;

`ifdef UDC_PRESCALER_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    udc_if #(.WIDTH(4)) a ();
    udc_if #(.WIDTH(4)) b ();

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .PRESCALE(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .PRESCALE(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [3:0] v);
        a.load = 1'b1;
        a.d_in = v;
        cyc();
        a.load = 1'b0;
    endtask

    task automatic load_b(input logic [3:0] v);
        b.load = 1'b1;
        b.d_in = v;
        cyc();
        b.load = 1'b0;
    endtask

    // One counter step: en held for a full prescaler period.
    task automatic step_a(input logic dir, input logic pol);
        a.up  = dir;
        a.sat = pol;
        a.en  = 1'b1;
        repeat (PS) cyc();
        a.en  = 1'b0;
    endtask

    task automatic step_b(input logic dir, input logic pol);
        b.up  = dir;
        b.sat = pol;
        b.en  = 1'b1;
        repeat (PS) cyc();
        b.en  = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        a.en = 1'b0; a.load = 1'b0; a.d_in = '0; a.up = UDC_UP; a.sat = UDC_WRAP; a.clr_flags = 1'b0;
        b.en = 1'b0; b.load = 1'b0; b.d_in = '0; b.up = UDC_UP; b.sat = UDC_WRAP; b.clr_flags = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;

        chk("rst_count",  32'(a.count), 0);
        chk("rst_at_min", 32'(a.at_min), 1);
        chk("rst_at_max", 32'(a.at_max), 0);
        chk("rst_tc",     32'(a.tc), 0);
        chk("rst_flags",  32'({a.ovf, a.unf}), 0);

        load_a(4'd7);
        chk("load7", 32'(a.count), 7);
        load_a(4'd13);
        chk("load13_clamp", 32'(a.count), 9);
        chk("load13_at_max", 32'(a.at_max), 1);
        chk("load13_tc", 32'(a.tc), 0);
        chk("load13_ovf", 32'(a.ovf), 0);

        load_a(4'd8);
        step_a(UDC_UP, UDC_WRAP);
        chk("upw1_count", 32'(a.count), 9);
        chk("upw1_tc", 32'(a.tc), 0);
        step_a(UDC_UP, UDC_WRAP);
        chk("upw2_count", 32'(a.count), 0);
        chk("upw2_tc", 32'(a.tc), 1);
        chk("upw2_ovf", 32'(a.ovf), 1);
        step_a(UDC_UP, UDC_WRAP);
        chk("upw3_count", 32'(a.count), 1);
        chk("upw3_tc", 32'(a.tc), 0);

        a.clr_flags = 1'b1;
        cyc();
        a.clr_flags = 1'b0;
        chk("clr_ovf", 32'(a.ovf), 0);

        load_a(4'd1);
        step_a(UDC_DOWN, UDC_SAT);
        chk("dns1_count", 32'(a.count), 0);
        chk("dns1_tc", 32'(a.tc), 0);
        chk("dns1_unf", 32'(a.unf), 0);
        step_a(UDC_DOWN, UDC_SAT);
        chk("dns2_count", 32'(a.count), 0);
        chk("dns2_tc", 32'(a.tc), 1);
        chk("dns2_unf", 32'(a.unf), 1);
        step_a(UDC_DOWN, UDC_SAT);
        chk("dns3_count", 32'(a.count), 0);
        chk("dns3_tc", 32'(a.tc), 1);
        chk("dns3_at_min", 32'(a.at_min), 1);
        a.clr_flags = 1'b1;
        cyc();
        a.clr_flags = 1'b0;
        chk("clr_unf", 32'(a.unf), 0);
        chk("clr_tc_drop", 32'(a.tc), 0);

        load_a(4'd2);
        rst = 1'b1; a.load = 1'b1; a.d_in = 4'd5; a.en = 1'b1; a.up = UDC_UP;
        cyc();
        rst = 1'b0; a.load = 1'b0; a.en = 1'b0;
        chk("prio_rst", 32'(a.count), 0);

        a.load = 1'b1; a.d_in = 4'd4; a.en = 1'b1; a.up = UDC_UP;
        cyc();
        a.load = 1'b0; a.en = 1'b0;
        chk("prio_load_en", 32'(a.count), 4);
        chk("prio_load_tc", 32'(a.tc), 0);

        load_a(4'd9);
        a.clr_flags = 1'b1;
        step_a(UDC_UP, UDC_WRAP);
        a.clr_flags = 1'b0;
        chk("set_wins_ovf", 32'(a.ovf), 1);
        chk("set_wins_count", 32'(a.count), 0);
        cyc();
        chk("hold_count", 32'(a.count), 0);
        chk("hold_tc", 32'(a.tc), 0);
        chk("hold_ovf", 32'(a.ovf), 1);

        a.clr_flags = 1'b1;
        cyc();
        a.clr_flags = 1'b0;
        load_a(4'd9);
        step_a(UDC_UP, UDC_SAT);
        chk("sat_max_count", 32'(a.count), 9);
        chk("sat_max_tc", 32'(a.tc), 1);
        chk("sat_max_ovf", 32'(a.ovf), 1);

        load_b(4'd1);
        step_b(UDC_DOWN, UDC_WRAP);
        chk("s3_dn_count", 32'(b.count), 8);
        chk("s3_dn_tc", 32'(b.tc), 1);
        chk("s3_dn_unf", 32'(b.unf), 1);
        step_b(UDC_UP, UDC_WRAP);
        chk("s3_up_count", 32'(b.count), 1);
        chk("s3_up_tc", 32'(b.tc), 1);
        chk("s3_up_ovf", 32'(b.ovf), 1);
        load_b(4'd5);
        step_b(UDC_DOWN, UDC_WRAP);
        chk("s3_dn5_count", 32'(b.count), 2);
        chk("s3_dn5_tc", 32'(b.tc), 0);

`ifdef UDC_PRESCALER_EN
        load_a(4'd0);
        a.up = UDC_UP; a.sat = UDC_WRAP; a.en = 1'b1;
        repeat (3) cyc();
        chk("pre_wait3", 32'(a.count), 0);
        cyc();
        chk("pre_tick1", 32'(a.count), 1);
        repeat (3) cyc();
        chk("pre_wait7", 32'(a.count), 1);
        cyc();
        chk("pre_tick2", 32'(a.count), 2);
        repeat (2) cyc();
        a.en = 1'b0;
        repeat (2) cyc();
        chk("pre_gap_hold", 32'(a.count), 2);
        a.en = 1'b1;
        cyc();
        chk("pre_gap_wait", 32'(a.count), 2);
        cyc();
        chk("pre_gap_tick", 32'(a.count), 3);
        repeat (2) cyc();
        a.load = 1'b1; a.d_in = 4'd5;
        cyc();
        a.load = 1'b0;
        chk("pre_load", 32'(a.count), 5);
        repeat (3) cyc();
        chk("pre_load_wait", 32'(a.count), 5);
        cyc();
        chk("pre_load_tick", 32'(a.count), 6);
        a.en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
